// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: tap-address sizing and common flag types.
package fifo_pkg;

    localparam int MAX_DEP = 128;

    // Occupancy wide enough for the largest supported depth (0..MAX_DEP).
    typedef logic [7:0] level_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
    } flags_t;

    // MSB index of a tap address that can reach entries 0..depth-1 (clog2(depth)-1, min 0).
    function automatic int tap_msb(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) w++;
        return (w < 1) ? 0 : w - 1;
    endfunction

endpackage

// File: rtl/srl_fifo_mem.sv
// Shift-register storage: every enabled write shifts the whole line by one entry.
// The read tap is a plain mux, so q follows the address combinationally.
module srl_fifo_mem #(
    parameter int WID = 8,
    parameter int DEP = 16,
    parameter int AW  = 4
) (
    input  logic           clk,
    input  logic           ce,
    input  logic [AW-1:0]  a,
    input  logic [WID-1:0] d,
    output logic [WID-1:0] q
);

    logic [WID-1:0] m [DEP];

    // NOTE: the delay line has no reset; entries above the occupancy count are never read.
    always_ff @(posedge clk) begin
        if (ce) begin
            m[0] <= d;
            for (int n = 1; n < DEP; n++) begin
                m[n] <= m[n-1];
            end
        end
    end

    // Tap values at or beyond DEP only occur while empty, where q is a don't-care.
    always_comb begin
        q = '0;
        for (int i = 0; i < DEP; i++) begin
            if (a == AW'(i)) q = m[i];
        end
    end

endmodule

// File: rtl/srl_fifo.sv
// First-word-fall-through FIFO built on a shift register: counter, flags and handshake.
// The oldest entry sits at tap cnt-1, so reads never move data, only the tap.
module srl_fifo
    import fifo_pkg::*;
#(
    parameter  int WID   = 8,
    parameter  int DEP   = 16,
    parameter  int AFULL = 12,
    localparam int AMSB  = tap_msb(DEP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            clr,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [WID-1:0]  s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [WID-1:0]  m_data,
    output logic [AMSB+1:0] level,
    output logic            full,
    output logic            empty,
    output logic            almost_full
);

    localparam int LW = AMSB + 2;

    logic [LW-1:0] cnt;
    logic [LW-1:0] cnt_m1;
    logic [AMSB:0] tap;
    logic          push;
    logic          pop;
    flags_t        flags;

    always_comb begin
        flags.full        = (cnt == LW'(DEP));
        flags.empty       = (cnt == '0);
        flags.almost_full = (cnt >= LW'(AFULL));
    end

    // s_ready deliberately ignores m_ready: a full FIFO refuses writes even while draining.
    assign s_ready     = ~flags.full & ~rst;
    assign m_valid     = ~flags.empty;
    assign full        = flags.full;
    assign empty       = flags.empty;
    assign almost_full = flags.almost_full;
    assign level       = cnt;

    assign push = ce & s_valid & s_ready;
    assign pop  = ce & m_valid & m_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ce && clr) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // A simultaneous push and pop shifts the next-oldest word into the same tap.
    assign cnt_m1 = cnt - LW'(1);
    assign tap    = cnt_m1[AMSB:0];

    srl_fifo_mem #(
        .WID (WID),
        .DEP (DEP),
        .AW  (AMSB + 1)
    ) u_mem (
        .clk (clk),
        .ce  (push),
        .a   (tap),
        .d   (s_data),
        .q   (m_data)
    );

    a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt <= LW'(DEP));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && cnt == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && cnt == LW'(DEP)));

endmodule

// File: tb/tb_srl_fifo.sv
// Directed and randomized bench for srl_fifo, checked against a queue-based model.
module tb_srl_fifo;

    localparam int WID   = 8;
    localparam int DEP   = 16;
    localparam int AFULL = 12;
    localparam int LW    = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           ce;
    logic           clr;
    logic           s_valid;
    logic           s_ready;
    logic [WID-1:0] s_data;
    logic           m_valid;
    logic           m_ready;
    logic [WID-1:0] m_data;
    logic [LW-1:0]  level;
    logic           full;
    logic           empty;
    logic           almost_full;

    int passed = 0;
    int total  = 0;

    logic [WID-1:0] model [$];

    always #5 clk = ~clk;

    srl_fifo #(
        .WID   (WID),
        .DEP   (DEP),
        .AFULL (AFULL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .clr         (clr),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        int n;
        n = model.size();
        check("level", 32'(level), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEP));
        check("almost_full", 32'(almost_full), 32'(n >= AFULL));
        check("m_valid", 32'(m_valid), 32'(n > 0));
        check("s_ready", 32'(s_ready), 32'(!rst && n < DEP));
        if (n > 0) check("m_data", 32'(m_data), 32'(model[0]));
    endtask

    task automatic drive(input logic sv, input logic [WID-1:0] sd, input logic mr,
                         input logic cl, input logic en);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        clr     = cl;
        ce      = en;
    endtask

    // One clock: predict the transfer from pre-edge inputs, advance the model, compare.
    task automatic tick();
        logic           do_push;
        logic           do_pop;
        logic [WID-1:0] sd;
        logic [WID-1:0] dropped;
        do_push = !rst && ce && !clr && s_valid && (model.size() < DEP);
        do_pop  = !rst && ce && !clr && m_ready && (model.size() > 0);
        sd      = s_data;
        @(posedge clk);
        if (rst || (ce && clr)) begin
            model.delete();
        end else begin
            if (do_pop) dropped = model.pop_front();
            if (do_push) model.push_back(sd);
        end
        #1;
        check_all();
    endtask

    task automatic push_n(input int n, input logic [WID-1:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + WID'(i), 1'b0, 1'b0, 1'b1);
            tick();
        end
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            tick();
        end
    endtask

    initial begin
        logic [LW-1:0]  held_level;
        logic [WID-1:0] held_data;

        // Reset held with a write pending: nothing may be stored, s_ready low.
        rst = 1'b1;
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();

        // Fill to full, try an extra write, then drain in order.
        push_n(DEP, 8'h01);
        check("full_at_16", 32'(full), 32'(1));
        drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        tick();
        pop_n(DEP);
        check("empty_after_drain", 32'(empty), 32'(1));

        // Pop on empty: no underflow.
        pop_n(2);

        // Steady-state push+pop at level 5.
        push_n(5, 8'h30);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'h40 + WID'(i), 1'b1, 1'b0, 1'b1);
            tick();
        end
        check("level_steady_5", 32'(level), 32'(5));

        // Full with simultaneous pop: write rejected, accepted next cycle, emerges last.
        push_n(DEP - 5, 8'h80);
        drive(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        tick();
        check("level_after_full_pop", 32'(level), 32'(DEP - 1));
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        tick();
        pop_n(DEP - 1);
        check("aa_last", 32'(m_data), 32'(8'hAA));
        pop_n(1);

        // Push into empty falls through next cycle.
        push_n(1, 8'h5A);
        check("fwft_5a", 32'(m_data), 32'(8'h5A));
        pop_n(3);

        // clr wins over push/pop.
        push_n(7, 8'h10);
        drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
        tick();
        check("level_after_clr", 32'(level), 32'(0));

        // ce low freezes everything.
        push_n(3, 8'h20);
        held_level = level;
        held_data  = m_data;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hC0 + WID'(i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("ce_hold_level", 32'(level), 32'(held_level));
        check("ce_hold_data", 32'(m_data), 32'(held_data));

        // Randomized traffic, including rare clr, ce gaps and mid-operation resets.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 99) < 60, WID'($urandom), $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 90);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
